// File: rtl/hi_lo_pkg.sv
// hi_lo_pkg: op/state encodings and SPECIAL funct decode for the HI/LO mul/div unit.
package hi_lo_pkg;
  typedef enum logic [2:0] {
    HL_NONE, HL_MTHI, HL_MTLO, HL_MULT, HL_MULTU, HL_DIV, HL_DIVU
  } hl_op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} hl_state_t;
  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] FN_MTHI = 6'b010001;
  localparam logic [5:0] FN_MTLO = 6'b010011;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV = 6'b011010;
  localparam logic [5:0] FN_DIVU = 6'b011011;
  function automatic hl_op_t decode_hl_op(input logic [5:0] opcode, input logic [5:0] funct);
    if (opcode != OPC_SPECIAL) return HL_NONE;
    return funct == FN_MTHI ? HL_MTHI :
           funct == FN_MTLO ? HL_MTLO :
           funct == FN_MULT ? HL_MULT :
           funct == FN_MULTU ? HL_MULTU :
           funct == FN_DIV ? HL_DIV :
           funct == FN_DIVU ? HL_DIVU : HL_NONE;
  endfunction
endpackage

// File: rtl/hi_lo_muldiv_unit_divider.sv
// hl_iter_divider: unsigned restoring divider, one quotient bit per cycle.
module hl_iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last_iter,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
  logic [WIDTH:0] shifted, diff;
  logic ge;
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff = shifted - {1'b0, dsr_q};
    ge = shifted >= {1'b0, dsr_q};
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dsr_d = dsr_q;
    if (start) begin
      cnt_d = CW'(WIDTH);
      quo_d = dividend;
      rem_d = '0;
      dsr_d = divisor;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ge};
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
    end
  // High while the final iteration is being clocked in
  assign last_iter = cnt_q == CW'(1);
  assign quotient = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/hi_lo_muldiv_unit.sv
// hi_lo_muldiv_unit: HI/LO registers with fixed-latency multiply and iterative divide.
module hi_lo_muldiv_unit
  import hi_lo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MULT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  hl_op_t           op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  hl_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic sgn_q, sgn_d, done_q, done_d;
  logic [2*WIDTH-1:0] pipe_q [MULT_CYCLES];
  logic [2*WIDTH-1:0] pipe_d [MULT_CYCLES];
  logic accept, is_mul, is_div, sgn, div_last, dz, qneg, rneg;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0] mag_a, mag_b, div_quo, div_rem, q_fix, r_fix;
  hl_iter_divider #(.WIDTH(WIDTH)) u_div (
    .clk(clk), .reset(reset), .start(accept && is_div),
    .dividend(mag_a), .divisor(mag_b),
    .last_iter(div_last), .quotient(div_quo), .remainder(div_rem)
  );
  always_comb begin
    accept = op_valid && state_q == ST_IDLE && op != HL_NONE;
    is_mul = op == HL_MULT || op == HL_MULTU;
    is_div = op == HL_DIV || op == HL_DIVU;
    sgn = op == HL_MULT || op == HL_DIV;
    ext_a = {{WIDTH{sgn & rs_val[WIDTH-1]}}, rs_val};
    ext_b = {{WIDTH{sgn & rt_val[WIDTH-1]}}, rt_val};
    prod = ext_a * ext_b;
    mag_a = (sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    mag_b = (sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    pipe_d[0] = prod;
    for (int i = 1; i < MULT_CYCLES; i++) pipe_d[i] = pipe_q[i-1];
    dz = b_q == '0;
    qneg = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    rneg = sgn_q & a_q[WIDTH-1];
    q_fix = qneg ? -div_quo : div_quo;
    r_fix = rneg ? -div_rem : div_rem;
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    a_d = a_q;
    b_d = b_q;
    sgn_d = sgn_q;
    done_d = 1'b0;
    if (accept) begin
      hi_d = op == HL_MTHI ? rs_val : hi_q;
      lo_d = op == HL_MTLO ? rs_val : lo_q;
      state_d = is_mul ? ST_MUL : is_div ? ST_DIV : ST_IDLE;
      cnt_d = 3'(MULT_CYCLES - 1);
      a_d = (is_mul || is_div) ? rs_val : a_q;
      b_d = (is_mul || is_div) ? rt_val : b_q;
      sgn_d = (is_mul || is_div) ? sgn : sgn_q;
    end
    if (state_q == ST_MUL) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd0) begin
        {hi_d, lo_d} = pipe_q[MULT_CYCLES-1];
        state_d = ST_IDLE;
        done_d = 1'b1;
      end
    end
    if (state_q == ST_DIV && div_last) state_d = ST_FIX;
    // Divide by zero returns the raw dividend, not the magnitude the core saw
    if (state_q == ST_FIX) begin
      hi_d = dz ? a_q : r_fix;
      lo_d = dz ? '1 : q_fix;
      state_d = ST_IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sgn_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < MULT_CYCLES; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      a_q <= a_d;
      b_q <= b_d;
      sgn_q <= sgn_d;
      done_q <= done_d;
      for (int i = 0; i < MULT_CYCLES; i++) pipe_q[i] <= pipe_d[i];
    end
  assign busy = state_q != ST_IDLE;
  assign ready = ~busy;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// tb_hi_lo_muldiv_unit: directed self-checking bench for the HI/LO mul/div unit.
module tb_hi_lo_muldiv_unit;
  import hi_lo_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b0, op_valid = 1'b0;
  hl_op_t op = HL_NONE;
  logic [W-1:0] rs_val = '0, rt_val = '0;
  logic ready, busy, done;
  logic [W-1:0] hi, lo;
  int checks = 0, errors = 0, lat;
  hi_lo_muldiv_unit #(.WIDTH(W), .MULT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .ready(ready), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input hl_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    op_valid = 1'b0; op = HL_NONE;
  endtask
  task automatic wait_done(input int start, output int n);
    n = start;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy_done_ready", {61'h0, busy, done, ready}, 64'h1);
    @(negedge clk) reset = 1'b0;
    // MULT -3 * 5, cycle by cycle
    issue(HL_MULT, 32'hFFFFFFFD, 32'h00000005);
    chk("mult_busy_e0", {62'h0, busy, ready}, 64'h2);
    @(posedge clk); #1;
    chk("mult_e1_state", {62'h0, busy, done}, 64'h2);
    chk("mult_e1_hilo", {hi, lo}, 64'h0);
    @(posedge clk); #1;
    chk("mult_e2_state", {62'h0, busy, done}, 64'h1);
    chk("mult_e2_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    @(posedge clk); #1;
    chk("mult_done_drop", 64'(done), 64'h0);
    issue(HL_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, lat);
    chk("multu_lat", 64'(lat), 64'd2);
    chk("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    issue(HL_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, lat);
    chk("mult_m1_hilo", {hi, lo}, 64'h00000000_00000001);
    // DIVU with ignored MTHI and MULT while busy
    issue(HL_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    op_valid = 1'b1; op = HL_MTHI; rs_val = 32'hAAAAAAAA;
    @(posedge clk); #1;
    chk("busy_mthi_ignored", 64'(hi), 64'h0);
    @(negedge clk);
    op = HL_MULT; rs_val = 32'h00000003; rt_val = 32'h00000003;
    @(posedge clk); #1;
    op_valid = 1'b0; op = HL_NONE;
    wait_done(2, lat);
    chk("divu_lat", 64'(lat), 64'd33);
    chk("divu_hilo", {hi, lo}, 64'h00000002_0000000E);
    @(posedge clk); #1;
    chk("no_queued_op", {62'h0, busy, done}, 64'h0);
    chk("no_queued_hilo", {hi, lo}, 64'h00000002_0000000E);
    issue(HL_DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_done(0, lat);
    chk("div_neg_lat", 64'(lat), 64'd33);
    chk("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(HL_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(0, lat);
    chk("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);
    issue(HL_DIV, 32'h12345678, 32'h0);
    wait_done(0, lat);
    chk("div_zero_lat", 64'(lat), 64'd33);
    chk("div_zero_hilo", {hi, lo}, 64'h12345678_FFFFFFFF);
    issue(HL_DIVU, 32'h80000005, 32'h0);
    wait_done(0, lat);
    chk("divu_zero_hilo", {hi, lo}, 64'h80000005_FFFFFFFF);
    issue(HL_DIV, 32'h00000007, 32'hFFFFFFFE);
    wait_done(0, lat);
    chk("div_negdsr_hilo", {hi, lo}, 64'h00000001_FFFFFFFD);
    issue(HL_MTLO, 32'h55555555, 32'h0);
    chk("mtlo_hilo", {hi, lo}, 64'h00000001_55555555);
    chk("mtlo_state", {62'h0, busy, done}, 64'h0);
    issue(HL_MTHI, 32'h0BADF00D, 32'h0);
    chk("mthi_hilo", {hi, lo}, 64'h0BADF00D_55555555);
    // Async reset in the middle of a divide
    issue(HL_DIVU, 32'hFFFFFFFF, 32'h3);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_hilo", {hi, lo}, 64'h0);
    chk("midrst_state", {61'h0, busy, done, ready}, 64'h1);
    @(negedge clk) reset = 1'b0;
    issue(HL_DIVU, 32'hFFFFFFFF, 32'd10);
    wait_done(0, lat);
    chk("postrst_lat", 64'(lat), 64'd33);
    chk("postrst_hilo", {hi, lo}, 64'h00000005_19999999);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hi_lo_muldiv_unit.md
Name: hi_lo_muldiv_unit

Overview:
- Parametrised successor to the single-cycle HI/LO register control.
- Owns the HI/LO architectural registers and performs MULT/MULTU through a fixed-latency multiply path and DIV/DIVU through an iterative restoring divider.
- Also handles MTHI/MTLO writes and exposes a busy/ready handshake so the CPU control stalls MFHI/MFLO and new HI/LO ops until results land.
- Sits beside the main ALU, fed by the decoder (op) and register file (rs/rt values).

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, product is 2*WIDTH.
- MULT_CYCLES, 2, cycles from accepted MULT/MULTU to HI/LO write; legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op_valid  in  1  request strobe; accepted only when ready=1
- op  in  3  hl_op_t from hi_lo_pkg (NONE, MTHI, MTLO, MULT, MULTU, DIV, DIVU)
- rs_val  in  WIDTH  operand A / MT source
- rt_val  in  WIDTH  operand B
- ready  out  1  unit idle; equals ~busy
- busy  out  1  multiply or divide in flight
- done  out  1  one-cycle pulse in the cycle HI/LO hold a new mul/div result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async): hi=0, lo=0, busy=0, done=0, state=IDLE, counters=0, operand latches=0. Reset mid-operation aborts the operation; no partial HI/LO write.
- Accept condition: op_valid & ready & op!=NONE, sampled at posedge. Requests while busy are ignored. The CPU must hold them, and the bench checks that they are dropped.
- IDLE + MTHI: hi<=rs_val at that edge. lo unchanged. No busy, no done.
- IDLE + MTLO: lo<=rs_val. Same rules as MTHI.
- IDLE + MULT/MULTU:
  - Latch operands and go to MUL with count=MULT_CYCLES-1.
  - busy=1 from the next cycle.
  - MULT: signed 2*WIDTH product. MULTU: zero-extended product.
  - When count reaches 0, {hi,lo}<=product at the edge MULT_CYCLES after acceptance, state->IDLE.
  - done=1 for the cycle following that edge.
- IDLE + DIV/DIVU:
  - Latch operands as magnitudes (DIVU: raw; DIV: absolute values with record of signs) and go to DIV.
  - DIV runs WIDTH shift-subtract iterations, one per cycle, then goes to FIX.
  - FIX: apply signs; quotient negated if signs differ, remainder takes dividend sign.
  - lo<=quotient, hi<=remainder, state->IDLE.
  - Total latency WIDTH+1 edges after acceptance (33 for WIDTH=32). done pulses the following cycle.
- Divide by zero (rt_val=0): still runs full latency. lo<=all ones, hi<=dividend (rs_val as given, signed or unsigned).
- Signed overflow (DIV, most-negative / -1): lo<=most-negative, hi<=0.
- hi/lo outputs are always the registered architectural values. Intermediate datapath values never appear on them.
- FSM: IDLE -> MUL -> IDLE; IDLE -> DIV -> FIX -> IDLE. No other transitions. Unused encodings go to IDLE.
- busy = (state != IDLE). ready = ~busy.
- done is never asserted with busy=0 for more than one cycle.

Decomposition:
- hi_lo_pkg:
  - hl_op_t enum (3 bits).
  - hl_state_t enum (IDLE, MUL, DIV, FIX).
  - Function decode_hl_op(opcode, funct) that maps SPECIAL funct codes MTHI=010001, MTLO=010011, MULT=011000, MULTU=011001, DIV=011010, DIVU=011011 to hl_op_t, else NONE.
- One sub-module: hl_iter_divider (WIDTH param). Contains the unsigned shift-subtract core with start/iter count/valid. The top module wraps it with sign handling and the FIX stage.
- Multiply path stays in the top module as a MULT_CYCLES-deep result shift pipeline.

Test Plan:
- MULT rs=FFFFFFFD (-3), rt=00000005 -> after 2 edges hi=FFFFFFFF, lo=FFFFFFF1, done pulse 1 cycle, busy for 2 cycles.
- MULTU rs=FFFFFFFF, rt=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Repeat with MULT -> hi=00000000, lo=00000001.
- DIVU 100/7 -> after 33 edges lo=0000000E, hi=00000002. DIV FFFFFFF9 (-7) / 2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0.
- DIV 12345678 / 0 -> lo=FFFFFFFF, hi=12345678 after full latency.
- During busy, issue MTHI rs=AAAAAAAA and MULT -> both ignored. After completion hi/lo hold only the first op's result. MTLO 55555555 when idle -> lo updates next edge, busy stays 0.
- Assert reset at iteration 10 of a DIVU -> hi=lo=0, busy=0 immediately (async). A new DIVU after reset completes correctly.
